xmit_traffic_gen: RTL and testbench

XMIT_TRAFFIC_GEN -- requirements
Module: xmit_traffic_gen

---
 rtl/xmit_traffic_gen_if.sv | 43 ++++
 rtl/xmit_traffic_gen.sv | 217 +++++++++++++++++++++
 tb/tb_xmit_traffic_gen.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xmit_traffic_gen_if.sv
// xmit_traffic_gen_if
// Transmit-side bundle between the traffic generator and the downstream sink.
//
// Signals:
//   f_data_in          payload beat (DATA_W bits)
//   f_ctrl_in          control block {len, len} (2*LEN_W bits), first beat only
//   f_rec_data_valid   payload beat valid
//   f_rec_frame_valid  control block valid, first beat only
//   f_hi_priority      current frame belongs to channel 0
//   tx_ready           downstream accept; a beat transfers on valid && ready
//
// Modports:
//   master  the generator (drives the frame signals, samples tx_ready)
//   slave   the sink (samples the frame signals, drives tx_ready)
interface xmit_traffic_gen_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 12
) ();
    logic [DATA_W-1:0]  f_data_in;
    logic [2*LEN_W-1:0] f_ctrl_in;
    logic               f_rec_data_valid;
    logic               f_rec_frame_valid;
    logic               f_hi_priority;
    logic               tx_ready;

    modport master (
        output f_data_in,
        output f_ctrl_in,
        output f_rec_data_valid,
        output f_rec_frame_valid,
        output f_hi_priority,
        input  tx_ready
    );

    modport slave (
        input  f_data_in,
        input  f_ctrl_in,
        input  f_rec_data_valid,
        input  f_rec_frame_valid,
        input  f_hi_priority,
        output tx_ready
    );
endinterface

// File: rtl/xmit_traffic_gen.sv
// xmit_traffic_gen
// Multi-channel frame traffic generator. A run is started with a start pulse,
// which latches the whole configuration. Frames are emitted on the tx bundle,
// channel by channel (round-robin or fixed), with an optional idle gap between
// frames, until the requested number of frames is sent or a stop is seen.
//
// Ports:
//   clk_sys          system clock (rising edge)
//   rst_n            asynchronous active-low reset
//   start / stop     run control pulses
//   cfg_mode         0 = round-robin over channels, 1 = fixed channel
//   cfg_fixed_ch     channel used in fixed mode
//   cfg_len          per-channel frame length in beats (channel c at slice c)
//   cfg_seed         per-channel initial payload seed (channel c at slice c)
//   cfg_incr         0 = constant payload per frame, 1 = seed + beat index
//   cfg_gap          idle cycles between frames
//   cfg_num_frames   frames per run, 0 = continuous
//   tx               transmit bundle (master side)
//   busy             run in progress
//   done             one-cycle pulse at end of run
//   frame_cnt        frames completed in the current or last run
module xmit_traffic_gen #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 12,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_sys,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     cfg_mode,
    input  logic [CH_W-1:0]          cfg_fixed_ch,
    input  logic [NUM_CH*LEN_W-1:0]  cfg_len,
    input  logic [NUM_CH*DATA_W-1:0] cfg_seed,
    input  logic                     cfg_incr,
    input  logic [7:0]               cfg_gap,
    input  logic [CNT_W-1:0]         cfg_num_frames,
    xmit_traffic_gen_if.master       tx,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FIRST = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    logic [1:0]              state_q;
    logic [CH_W-1:0]         ch_q;
    logic                    mode_q;
    logic [CH_W-1:0]         fixed_ch_q;
    logic [NUM_CH*LEN_W-1:0] len_q;
    logic                    incr_q;
    logic [7:0]              gap_q;
    logic [CNT_W-1:0]        num_frames_q;
    logic [DATA_W-1:0]       seed_q [NUM_CH];
    logic [LEN_W-1:0]        beat_q;
    logic [7:0]              gap_cnt_q;
    logic [CNT_W-1:0]        frame_cnt_q;
    logic                    stop_seen_q;
    logic                    done_q;

    logic                    sel_mode;
    logic [CH_W-1:0]         sel_fixed;
    logic [NUM_CH*LEN_W-1:0] sel_lens;
    logic [CH_W-1:0]         sel_base;
    logic                    sel_found;
    logic [CH_W-1:0]         sel_ch;
    logic [LEN_W-1:0]        cur_len;
    logic                    xfer;
    logic                    last_beat;
    logic                    run_complete;

    // Channel selection. In IDLE the incoming configuration is used and the
    // search starts after the last channel, so channel 0 is tried first;
    // during a run the latched configuration is used, starting after the
    // current channel. The descending loop leaves the nearest nonzero
    // successor in sel_ch.
    always_comb begin
        sel_mode  = (state_q == IDLE) ? cfg_mode     : mode_q;
        sel_fixed = (state_q == IDLE) ? cfg_fixed_ch : fixed_ch_q;
        sel_lens  = (state_q == IDLE) ? cfg_len      : len_q;
        sel_base  = (state_q == IDLE) ? CH_W'(NUM_CH - 1) : ch_q;
        sel_found = 1'b0;
        sel_ch    = '0;
        if (sel_mode) begin
            if (int'(sel_fixed) < NUM_CH &&
                sel_lens[int'(sel_fixed)*LEN_W +: LEN_W] != '0) begin
                sel_found = 1'b1;
                sel_ch    = sel_fixed;
            end
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                if (sel_lens[((int'(sel_base) + k) % NUM_CH)*LEN_W +: LEN_W] != '0) begin
                    sel_found = 1'b1;
                    sel_ch    = CH_W'((int'(sel_base) + k) % NUM_CH);
                end
            end
        end
    end

    // A stop arriving on the final beat still ends the run after this frame.
    always_comb begin
        cur_len      = len_q[int'(ch_q)*LEN_W +: LEN_W];
        xfer         = (state_q == FIRST || state_q == DATA) && tx.tx_ready;
        last_beat    = (beat_q == cur_len - LEN_W'(1));
        run_complete = stop_seen_q || stop ||
                       (num_frames_q != '0 && (frame_cnt_q + CNT_W'(1)) == num_frames_q);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            mode_q       <= 1'b0;
            fixed_ch_q   <= '0;
            len_q        <= '0;
            incr_q       <= 1'b0;
            gap_q        <= '0;
            num_frames_q <= '0;
            for (int c = 0; c < NUM_CH; c++) seed_q[c] <= '0;
            beat_q       <= '0;
            gap_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            stop_seen_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q       <= cfg_mode;
                        fixed_ch_q   <= cfg_fixed_ch;
                        len_q        <= cfg_len;
                        incr_q       <= cfg_incr;
                        gap_q        <= cfg_gap;
                        num_frames_q <= cfg_num_frames;
                        for (int c = 0; c < NUM_CH; c++)
                            seed_q[c] <= cfg_seed[c*DATA_W +: DATA_W];
                        frame_cnt_q  <= '0;
                        beat_q       <= '0;
                        stop_seen_q  <= stop;
                        if (sel_found) begin
                            ch_q    <= sel_ch;
                            state_q <= FIRST;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                FIRST, DATA: begin
                    if (stop) stop_seen_q <= 1'b1;
                    if (xfer) begin
                        if (last_beat) begin
                            beat_q       <= '0;
                            seed_q[ch_q] <= seed_q[ch_q] + DATA_W'(1);
                            frame_cnt_q  <= frame_cnt_q + CNT_W'(1);
                            if (run_complete) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                ch_q <= sel_ch;
                                if (gap_q == '0) begin
                                    state_q <= FIRST;
                                end else begin
                                    gap_cnt_q <= gap_q;
                                    state_q   <= GAP;
                                end
                            end
                        end else begin
                            beat_q  <= beat_q + LEN_W'(1);
                            state_q <= DATA;
                        end
                    end
                end
                GAP: begin
                    if (stop) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (gap_cnt_q == 8'd1) begin
                        state_q <= FIRST;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs follow registered state only, so a stall holds them unchanged
    // and reset forces them to zero without waiting for a clock edge.
    always_comb begin
        tx.f_data_in         = '0;
        tx.f_ctrl_in         = '0;
        tx.f_rec_data_valid  = 1'b0;
        tx.f_rec_frame_valid = 1'b0;
        tx.f_hi_priority     = 1'b0;
        if (state_q == FIRST || state_q == DATA) begin
            tx.f_rec_data_valid = 1'b1;
            tx.f_hi_priority    = (ch_q == '0);
            tx.f_data_in        = seed_q[ch_q] + (incr_q ? DATA_W'(beat_q) : '0);
            if (state_q == FIRST) begin
                tx.f_rec_frame_valid = 1'b1;
                tx.f_ctrl_in         = {cur_len, cur_len};
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_xmit_traffic_gen.sv
// tb_xmit_traffic_gen
// Directed testbench for xmit_traffic_gen: a two-channel instance for most
// scenarios and a four-channel instance for channel skipping.
module tb_xmit_traffic_gen;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 12;
    localparam int CNT_W  = 16;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;

    always #5 clk_sys = ~clk_sys;

    logic                 start, stop, cfg_mode, cfg_incr;
    logic [0:0]           cfg_fixed_ch;
    logic [2*LEN_W-1:0]   cfg_len;
    logic [2*DATA_W-1:0]  cfg_seed;
    logic [7:0]           cfg_gap;
    logic [CNT_W-1:0]     cfg_num_frames;
    logic                 busy, done;
    logic [CNT_W-1:0]     frame_cnt;

    logic                 start4, stop4, cfg_mode4, cfg_incr4;
    logic [1:0]           cfg_fixed_ch4;
    logic [4*LEN_W-1:0]   cfg_len4;
    logic [4*DATA_W-1:0]  cfg_seed4;
    logic [7:0]           cfg_gap4;
    logic [CNT_W-1:0]     cfg_num_frames4;
    logic                 busy4, done4;
    logic [CNT_W-1:0]     frame_cnt4;

    int checks   = 0;
    int failures = 0;

    xmit_traffic_gen_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) txif ();
    xmit_traffic_gen_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) txif4 ();

    xmit_traffic_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .NUM_CH(2), .CNT_W(CNT_W)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_mode(cfg_mode), .cfg_fixed_ch(cfg_fixed_ch), .cfg_len(cfg_len),
        .cfg_seed(cfg_seed), .cfg_incr(cfg_incr), .cfg_gap(cfg_gap),
        .cfg_num_frames(cfg_num_frames), .tx(txif), .busy(busy), .done(done),
        .frame_cnt(frame_cnt)
    );

    xmit_traffic_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .NUM_CH(4), .CNT_W(CNT_W)) dut4 (
        .clk_sys(clk_sys), .rst_n(rst_n), .start(start4), .stop(stop4),
        .cfg_mode(cfg_mode4), .cfg_fixed_ch(cfg_fixed_ch4), .cfg_len(cfg_len4),
        .cfg_seed(cfg_seed4), .cfg_incr(cfg_incr4), .cfg_gap(cfg_gap4),
        .cfg_num_frames(cfg_num_frames4), .tx(txif4), .busy(busy4), .done(done4),
        .frame_cnt(frame_cnt4)
    );

    // One clock, then settle past the edge before sampling or driving.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic mode, input logic fch,
                                 input logic [LEN_W-1:0] len0, input logic [LEN_W-1:0] len1,
                                 input logic [7:0] seed0, input logic [7:0] seed1,
                                 input logic incr, input logic [7:0] gap,
                                 input logic [CNT_W-1:0] nf);
        cfg_mode       = mode;
        cfg_fixed_ch   = fch;
        cfg_len        = {len1, len0};
        cfg_seed       = {seed1, seed0};
        cfg_incr       = incr;
        cfg_gap        = gap;
        cfg_num_frames = nf;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int bad;
        int ch;
        int len;
        logic [7:0]  ed;
        logic [23:0] ectrl;

        start = 0; stop = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        txif.tx_ready  = 1'b1;
        txif4.tx_ready = 1'b1;
        start4 = 0; stop4 = 0; cfg_mode4 = 0; cfg_incr4 = 0; cfg_fixed_ch4 = 0;
        cfg_len4 = '0; cfg_seed4 = '0; cfg_gap4 = 0; cfg_num_frames4 = 0;

        $display("[TB] reset state");
        repeat (3) tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_dvalid", txif.f_rec_data_valid, 0);
        checkOutput("rst_data", txif.f_data_in, 0);
        checkOutput("rst_frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        checkOutput("idle_after_release", busy, 0);

        $display("[TB] round-robin two channels, four frames");
        applyStimulus(0, 0, 512, 64, 8'hF0, 8'h00, 0, 0, 4);
        pulseStart();
        for (int f = 0; f < 4; f++) begin
            ch    = f % 2;
            len   = (ch == 0) ? 512 : 64;
            ed    = (ch == 0) ? 8'(8'hF0 + f / 2) : 8'(f / 2);
            ectrl = (ch == 0) ? 24'h200200 : 24'h040040;
            checkOutput($sformatf("t1_f%0d_ctrl", f), txif.f_ctrl_in, ectrl);
            checkOutput($sformatf("t1_f%0d_fvalid", f), txif.f_rec_frame_valid, 1);
            checkOutput($sformatf("t1_f%0d_hi", f), txif.f_hi_priority, (ch == 0));
            checkOutput($sformatf("t1_f%0d_data", f), txif.f_data_in, ed);
            bad = 0;
            for (int b = 0; b < len; b++) begin
                if (txif.f_rec_data_valid !== 1'b1 || txif.f_data_in !== ed ||
                    txif.f_hi_priority !== (ch == 0) ||
                    (b > 0 && (txif.f_rec_frame_valid !== 1'b0 || txif.f_ctrl_in !== '0)))
                    bad++;
                tick();
            end
            checkOutput($sformatf("t1_f%0d_beats", f), bad, 0);
        end
        checkOutput("t1_done", done, 1);
        checkOutput("t1_busy", busy, 0);
        checkOutput("t1_frame_cnt", frame_cnt, 4);
        tick();
        checkOutput("t1_done_one_cycle", done, 0);
        checkOutput("t1_frame_cnt_hold", frame_cnt, 4);

        $display("[TB] one-beat frames, fixed channel, incrementing payload");
        applyStimulus(1, 0, 1, 5, 8'hFE, 8'h00, 1, 0, 3);
        pulseStart();
        checkOutput("t2_frame_cnt_clear", frame_cnt, 0);
        for (int k = 0; k < 3; k++) begin
            ed = 8'(8'hFE + k);
            checkOutput($sformatf("t2_f%0d_data", k), txif.f_data_in, ed);
            checkOutput($sformatf("t2_f%0d_both_valid", k),
                        {txif.f_rec_data_valid, txif.f_rec_frame_valid}, 2'b11);
            checkOutput($sformatf("t2_f%0d_ctrl", k), txif.f_ctrl_in, 24'h001001);
            tick();
        end
        checkOutput("t2_done", done, 1);
        checkOutput("t2_frame_cnt", frame_cnt, 3);

        $display("[TB] stall on third beat");
        applyStimulus(1, 0, 4, 5, 8'hFE, 8'h00, 1, 0, 1);
        pulseStart();
        checkOutput("t3_b0", txif.f_data_in, 8'hFE);
        tick();
        checkOutput("t3_b1", txif.f_data_in, 8'hFF);
        tick();
        checkOutput("t3_b2", txif.f_data_in, 8'h00);
        txif.tx_ready = 1'b0;
        bad = 0;
        repeat (3) begin
            tick();
            if (txif.f_data_in !== 8'h00 || txif.f_rec_data_valid !== 1'b1 ||
                txif.f_rec_frame_valid !== 1'b0 || frame_cnt !== '0)
                bad++;
        end
        checkOutput("t3_stall_hold", bad, 0);
        txif.tx_ready = 1'b1;
        tick();
        checkOutput("t3_b3", txif.f_data_in, 8'h01);
        tick();
        checkOutput("t3_done", done, 1);
        checkOutput("t3_frame_cnt", frame_cnt, 1);

        $display("[TB] gap of five, stop mid-frame");
        applyStimulus(1, 0, 3, 5, 8'h10, 8'h00, 0, 5, 0);
        pulseStart();
        checkOutput("t4_f0_data", txif.f_data_in, 8'h10);
        tick();
        tick();
        checkOutput("t4_f0_last_valid", txif.f_rec_data_valid, 1);
        tick();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (txif.f_rec_data_valid !== 1'b0 || txif.f_rec_frame_valid !== 1'b0 ||
                txif.f_data_in !== '0 || busy !== 1'b1)
                bad++;
            tick();
        end
        checkOutput("t4_gap_idle", bad, 0);
        checkOutput("t4_f1_fvalid", txif.f_rec_frame_valid, 1);
        checkOutput("t4_f1_data", txif.f_data_in, 8'h11);
        checkOutput("t4_f1_frame_cnt", frame_cnt, 1);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("t4_f1_completes", {txif.f_rec_data_valid, txif.f_data_in}, {1'b1, 8'h11});
        tick();
        checkOutput("t4_done", done, 1);
        checkOutput("t4_frame_cnt", frame_cnt, 2);
        bad = 0;
        repeat (10) begin
            tick();
            if (txif.f_rec_data_valid !== 1'b0 || txif.f_rec_frame_valid !== 1'b0 || busy !== 1'b0)
                bad++;
        end
        checkOutput("t4_no_more_frames", bad, 0);

        $display("[TB] stop during gap");
        applyStimulus(1, 0, 1, 5, 8'h20, 8'h00, 0, 5, 0);
        pulseStart();
        checkOutput("t5_fvalid", txif.f_rec_frame_valid, 1);
        tick();
        checkOutput("t5_in_gap", {busy, txif.f_rec_data_valid}, 2'b10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("t5_done", {done, busy}, 2'b10);
        checkOutput("t5_frame_cnt", frame_cnt, 1);

        $display("[TB] start and stop together");
        applyStimulus(1, 0, 2, 5, 8'h30, 8'h00, 0, 0, 0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("t6_first", txif.f_rec_frame_valid, 1);
        tick();
        checkOutput("t6_data", {txif.f_rec_data_valid, txif.f_rec_frame_valid}, 2'b10);
        tick();
        checkOutput("t6_done", done, 1);
        checkOutput("t6_frame_cnt", frame_cnt, 1);

        $display("[TB] reset mid-frame");
        applyStimulus(1, 0, 200, 5, 8'h33, 8'h00, 0, 0, 0);
        pulseStart();
        repeat (100) tick();
        checkOutput("t7_before_reset", {txif.f_rec_data_valid, txif.f_hi_priority, txif.f_data_in},
                    {1'b1, 1'b1, 8'h33});
        rst_n = 1'b0;
        #1;
        checkOutput("t7_async_outputs", {txif.f_rec_data_valid, txif.f_rec_frame_valid,
                    txif.f_hi_priority, txif.f_data_in, busy}, '0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checkOutput("t7_stays_idle", {busy, txif.f_rec_data_valid}, 2'b00);

        $display("[TB] four channels with zero-length skipping");
        cfg_mode4       = 1'b0;
        cfg_len4        = {12'd8, 12'd0, 12'd0, 12'd8};
        cfg_seed4       = {8'hD0, 8'h00, 8'h00, 8'hA0};
        cfg_num_frames4 = 4;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int f = 0; f < 4; f++) begin
            ch = (f % 2 == 0) ? 0 : 3;
            ed = (ch == 0) ? 8'(8'hA0 + f / 2) : 8'(8'hD0 + f / 2);
            checkOutput($sformatf("t8_f%0d_fvalid", f), txif4.f_rec_frame_valid, 1);
            checkOutput($sformatf("t8_f%0d_data", f), txif4.f_data_in, ed);
            checkOutput($sformatf("t8_f%0d_hi", f), txif4.f_hi_priority, (ch == 0));
            repeat (8) tick();
        end
        checkOutput("t8_done", done4, 1);
        checkOutput("t8_frame_cnt", frame_cnt4, 4);
        cfg_len4 = '0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        checkOutput("t9_all_zero_done", {done4, busy4}, 2'b10);
        checkOutput("t9_all_zero_frame_cnt", frame_cnt4, 0);
        tick();
        checkOutput("t9_done_one_cycle", done4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
